// File: rtl/ntr_pkg.sv
// Shared opcode/LED constants and the opcode-to-LED decode for the NTR bus sniffer.
package ntr_pkg;

  localparam logic [7:0] OP_HEADER = 8'h00;
  localparam logic [7:0] OP_DUMMY  = 8'h9F;
  localparam logic [7:0] OP_CHIPID = 8'h90;

  localparam logic [3:0] LED_HEADER = 4'b0001;
  localparam logic [3:0] LED_DUMMY  = 4'b0010;
  localparam logic [3:0] LED_CHIPID = 4'b0100;
  localparam logic [3:0] LED_OTHER  = 4'b1000;

  localparam int CMD_LEN = 8;

  function automatic logic [3:0] led_decode(input logic [7:0] op);
    case (op)
      OP_HEADER: return LED_HEADER;
      OP_DUMMY:  return LED_DUMMY;
      OP_CHIPID: return LED_CHIPID;
      default:   return LED_OTHER;
    endcase
  endfunction

endpackage

// File: rtl/ntr_if.sv
// Card-bus bundle: the driver (card/host) is master, the sniffer is slave.
interface ntr_if;
  logic [7:0] ntr_data;
  logic       ntr_clk;
  logic       ntr_cs1;

  modport master (output ntr_data, output ntr_clk, output ntr_cs1);
  modport slave  (input  ntr_data, input  ntr_clk, input  ntr_cs1);
endinterface

// File: rtl/ntr_byte_rx.sv
// Bus sampling, ntr_clk rise detect, command byte counter and opcode latch.
// Define NTR_SYNC_EN to insert 2-flop synchronizers on every bus input.
module ntr_byte_rx
  import ntr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  ntr_if.slave       bus,
  output logic       cmd_done,
  output logic [7:0] opcode
);

  localparam logic [3:0] CNT_LAST = 4'(CMD_LEN - 1);
  localparam logic [3:0] CNT_MAX  = 4'(CMD_LEN);

  logic       clk_s, cs_s;
  logic [7:0] dat_s;

`ifdef NTR_SYNC_EN
  // All three inputs go through identical depth so data stays aligned with its clock.
  logic [1:0]      clk_sync_q, clk_sync_d;
  logic [1:0]      cs_sync_q,  cs_sync_d;
  logic [1:0][7:0] dat_sync_q, dat_sync_d;

  always_comb begin
    clk_sync_d = {clk_sync_q[0], bus.ntr_clk};
    cs_sync_d  = {cs_sync_q[0],  bus.ntr_cs1};
    dat_sync_d = {dat_sync_q[0], bus.ntr_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= 2'b11;
      cs_sync_q  <= 2'b11;
      dat_sync_q <= '0;
    end else begin
      clk_sync_q <= clk_sync_d;
      cs_sync_q  <= cs_sync_d;
      dat_sync_q <= dat_sync_d;
    end
  end

  assign clk_s = clk_sync_q[1];
  assign cs_s  = cs_sync_q[1];
  assign dat_s = dat_sync_q[1];
`else
  assign clk_s = bus.ntr_clk;
  assign cs_s  = bus.ntr_cs1;
  assign dat_s = bus.ntr_data;
`endif

  logic       clk_prev_q, clk_prev_d;
  logic [3:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] opcode_q,   opcode_d;
  logic       cap;

  // Select-high wins over a coincident edge; history tracks ntr_clk regardless of select.
  always_comb begin
    clk_prev_d = clk_s;
    cap        = clk_s & ~clk_prev_q & ~cs_s;
    byte_cnt_d = byte_cnt_q;
    opcode_d   = opcode_q;
    if (cs_s) begin
      byte_cnt_d = '0;
    end else if (cap && byte_cnt_q != CNT_MAX) begin
      byte_cnt_d = byte_cnt_q + 4'd1;
      if (byte_cnt_q == '0) opcode_d = dat_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_prev_q <= 1'b1;
      byte_cnt_q <= '0;
      opcode_q   <= '0;
    end else begin
      clk_prev_q <= clk_prev_d;
      byte_cnt_q <= byte_cnt_d;
      opcode_q   <= opcode_d;
    end
  end

  assign cmd_done = cap && (byte_cnt_q == CNT_LAST);
  assign opcode   = opcode_q;

endmodule

// File: rtl/ntr_top.sv
// NTR cartridge-bus command sniffer: shows the last complete command's opcode class on led.
// Input synchronizers are present when NTR_SYNC_EN is defined.
module ntr_top
  import ntr_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ntr_data,
  input  logic       ntr_clk,
  input  logic       ntr_cs1,
  output logic [3:0] led
);

  ntr_if bus ();
  assign bus.ntr_data = ntr_data;
  assign bus.ntr_clk  = ntr_clk;
  assign bus.ntr_cs1  = ntr_cs1;

  logic       cmd_done;
  logic [7:0] opcode;

  ntr_byte_rx u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .cmd_done (cmd_done),
    .opcode   (opcode)
  );

  logic [3:0] led_q, led_d;

  // opcode_q is already latched by the time the 8th byte completes the command.
  always_comb begin
    led_d = led_q;
    if (cmd_done) led_d = led_decode(opcode);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_q <= '0;
    else        led_q <= led_d;
  end

  assign led = led_q;

endmodule

// File: tb/tb_ntr_top.sv
// Randomized scoreboard bench for ntr_top: window-level model predicts LED changes,
// an independent monitor compares every observed LED change against the queue.
module tb_ntr_top;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] led;

  ntr_if bus ();

  always #5 clk = ~clk;

  ntr_top dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ntr_data (bus.ntr_data),
    .ntr_clk  (bus.ntr_clk),
    .ntr_cs1  (bus.ntr_cs1),
    .led      (led)
  );

  typedef struct {
    logic [3:0] led;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  logic [3:0] model_led = 4'b0000;
  logic [3:0] seen_led = 4'b0000;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] ref_led(input logic [7:0] op);
    if (op == 8'h00) return 4'b0001;
    if (op == 8'h9F) return 4'b0010;
    if (op == 8'h90) return 4'b0100;
    return 4'b1000;
  endfunction

  task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every LED change while out of reset must match the head of the queue in time.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && led !== seen_led) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL led_unexpected: got %b expected no change from %b", led, seen_led);
        end else begin
          e = q.pop_front();
          check4("led_value", led, e.led);
          n_chk++;
          if (cyc - e.cyc >= 1 && cyc - e.cyc <= 3) n_pass++;
          else $display("FAIL led_latency: got %0d cycles expected 1..3", cyc - e.cyc);
        end
        seen_led = led;
      end
    end
  end

  // One select window: cs1 falls with ntr_clk high (no capture), bytes on rises,
  // cs1 rises before ntr_clk returns high.
  task automatic window(input logic [7:0] b[$], input int abort_at);
    logic [3:0] e;
    bus.ntr_cs1 = 1'b0;
    wait_clk(4);
    bus.ntr_clk = 1'b0;
    wait_clk(4);
    for (int i = 0; i < b.size(); i++) begin
      if (i == abort_at) begin
        rst_n = 1'b0;
        #1;
        check4("reset_mid_cmd", led, 4'b0000);
        q.delete();
        model_led = 4'b0000;
        seen_led  = 4'b0000;
        wait_clk(2);
        rst_n = 1'b1;
        wait_clk(4);
      end
      bus.ntr_data = b[i];
      wait_clk(4);
      if (i == 7 && abort_at > 7) begin
        e = ref_led(b[0]);
        if (e != model_led) q.push_back('{led: e, cyc: cyc});
        model_led = e;
      end
      bus.ntr_clk = 1'b1;
      wait_clk(4);
      bus.ntr_clk = 1'b0;
    end
    wait_clk(4);
    bus.ntr_cs1 = 1'b1;
    wait_clk(4);
    bus.ntr_clk = 1'b1;
    wait_clk(4);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] bq[$];
    int         n, sel;
    bus.ntr_clk  = 1'b1;
    bus.ntr_cs1  = 1'b1;
    bus.ntr_data = 8'h00;
    wait_clk(3);
    check4("reset_state", led, 4'b0000);
    rst_n = 1'b1;
    wait_clk(4);

    // Chip ID
    bq = {8'h90, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    window(bq, 99);
    wait_clk(6);
    check4("chipid_hold", led, 4'b0100);

    // Reset mid-command; remaining bytes must not complete anything
    bq = {8'h9F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    window(bq, 5);
    check4("after_reset_partial", led, 4'b0000);

    // Short command
    bq = {8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    window(bq, 99);
    check4("short_cmd", led, 4'b0000);

    // Full unknown then header
    bq = {8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
    window(bq, 99);
    wait_clk(4);
    check4("unknown", led, 4'b1000);
    bq = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    window(bq, 99);
    wait_clk(4);
    check4("header", led, 4'b0001);

    // Dummy with 16 data-phase rises
    bq = {8'h9F};
    for (int i = 0; i < 23; i++) bq.push_back(8'h00);
    window(bq, 99);
    check4("dummy_data_phase", led, 4'b0010);

    // Rises with select high: no capture
    for (int i = 0; i < 10; i++) begin
      bus.ntr_data = 8'h90;
      bus.ntr_clk  = 1'b0;
      wait_clk(4);
      bus.ntr_clk  = 1'b1;
      wait_clk(4);
    end
    bq = {8'hFF, 8'h00, 8'h00};
    window(bq, 99);
    check4("edges_outside_cs", led, 4'b0010);

    // Randomized windows
    for (int w = 0; w < 40; w++) begin
      n   = $urandom_range(1, 14);
      sel = $urandom_range(0, 3);
      bq  = {};
      case (sel)
        0: bq.push_back(8'h00);
        1: bq.push_back(8'h9F);
        2: bq.push_back(8'h90);
        default: bq.push_back(8'($urandom));
      endcase
      for (int i = 1; i < n; i++) bq.push_back(8'($urandom));
      window(bq, 99);
    end

    wait_clk(10);
    n_chk++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL pending_expect: got %0d outstanding expected 0", q.size());
    check4("final_led", led, model_led);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
